// File: rtl/scpad_frontend_arb_pkg.sv
// Shared types and constants for the scratchpad frontend arbiter.
// A row request carries the per-column slot, crossbar shift, active mask and write data.
package scpad_frontend_arb_pkg;

    localparam int NUM_COLS = 4;
    localparam int ROW_W    = 5;
    localparam int SLOT_W   = NUM_COLS * ROW_W;
    localparam int SHIFT_W  = NUM_COLS * $clog2(NUM_COLS);
    localparam int MASK_W   = NUM_COLS;
    localparam int DATA_W   = NUM_COLS * 8;

    typedef logic [SLOT_W-1:0]  slot_mask_t;
    typedef logic [SHIFT_W-1:0] shift_mask_t;
    typedef logic [MASK_W-1:0]  valid_mask_t;
    typedef logic [DATA_W-1:0]  scpad_data_t;

    typedef struct packed {
        logic        write;
        slot_mask_t  slot;
        shift_mask_t shift;
        valid_mask_t mask;
        scpad_data_t data;
    } scpad_req_t;

    localparam int FE_REQ_BACKEND = 0;
    localparam int FE_REQ_SA      = 1;
    localparam int FE_REQ_VC      = 2;
    localparam int FE_NUM_REQ     = 3;

    // Round-robin successor of idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/scpad_frontend_arb_if.sv
// Requester-side and SRAM-controller-side bundle of the frontend arbiter.
// master = requesters plus SRAM controller, slave = the arbiter.
interface scpad_frontend_arb_if
    import scpad_frontend_arb_pkg::*;
#(
    parameter int NUM_REQ = FE_NUM_REQ
) ();
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              req_write;
    slot_mask_t  [NUM_REQ-1:0]       req_slot;
    shift_mask_t [NUM_REQ-1:0]       req_shift;
    valid_mask_t [NUM_REQ-1:0]       req_mask;
    scpad_data_t [NUM_REQ-1:0]       req_wdata;

    logic                            sram_valid;
    logic                            sram_ready;
    logic                            sram_write;
    slot_mask_t                      sram_slot;
    shift_mask_t                     sram_shift;
    valid_mask_t                     sram_mask;
    scpad_data_t                     sram_wdata;
    logic [IDW-1:0]                  sram_id;
    logic                            sram_rsp_valid;
    scpad_data_t                     sram_rsp_data;

    logic [NUM_REQ-1:0]              rsp_valid;
    scpad_data_t                     rsp_data;
    logic                            err_rsp_unf;

    modport master (
        output req_valid, req_write, req_slot, req_shift, req_mask, req_wdata,
        output sram_ready, sram_rsp_valid, sram_rsp_data,
        input  req_ready, sram_valid, sram_write, sram_slot, sram_shift, sram_mask,
        input  sram_wdata, sram_id, rsp_valid, rsp_data, err_rsp_unf
    );

    modport slave (
        input  req_valid, req_write, req_slot, req_shift, req_mask, req_wdata,
        input  sram_ready, sram_rsp_valid, sram_rsp_data,
        output req_ready, sram_valid, sram_write, sram_slot, sram_shift, sram_mask,
        output sram_wdata, sram_id, rsp_valid, rsp_data, err_rsp_unf
    );

endinterface

// File: rtl/scpad_frontend_arb_rsp_id_fifo.sv
// In-order FIFO of requester ids for reads awaiting their SRAM response.
// A push and a pop in the same cycle are both honoured, even when full.
module scpad_rsp_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  logic [W-1:0] push_id,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == CW'(0));
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_id;
                wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/scpad_frontend_arb.sv
// Arbitrates the scratchpad SRAM port between NUM_REQ requesters (round-robin with
// aging urgency), registers the winner, and steers in-order read responses back.
module scpad_frontend_arb
    import scpad_frontend_arb_pkg::*;
#(
    parameter int NUM_REQ   = FE_NUM_REQ,
    parameter int RSP_DEPTH = 4,
    parameter int AGE_MAX   = 15
) (
    input logic                 CLK,
    input logic                 nRST,
    scpad_frontend_arb_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int AW  = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;

    scpad_req_t         stage_r;
    logic               sram_valid_r;
    logic [IDW-1:0]     sram_id_r;
    logic [IDW-1:0]     rr_ptr_r;
    logic [CW-1:0]      out_cnt_r;
    logic [AW-1:0]      age_r [NUM_REQ];
    logic               err_r;

    logic               stage_free_s;
    logic               read_ok_s;
    logic               any_urgent_s;
    logic               win_found_s;
    logic               grant_s;
    logic               grant_read_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_pop_s;
    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] urgent_s;
    logic [NUM_REQ-1:0] pool_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [NUM_REQ-1:0] rsp_valid_s;
    logic [IDW-1:0]     win_id_s;
    logic [IDW-1:0]     cand_s;
    logic [IDW-1:0]     fifo_head_s;

    // Gating with nRST keeps req_ready low while the block is held in reset.
    assign stage_free_s = nRST && (!sram_valid_r || bus.sram_ready);
    assign read_ok_s    = (out_cnt_r < CW'(RSP_DEPTH)) && !fifo_full_s;
    assign grant_s      = stage_free_s && win_found_s;
    assign grant_read_s = grant_s && !bus.req_write[win_id_s];
    assign fifo_pop_s   = bus.sram_rsp_valid && !fifo_empty_s;

    // Eligibility, urgency and the candidate pool for this cycle.
    always_comb begin
        elig_s   = '0;
        urgent_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i]   = bus.req_valid[i] && (bus.req_write[i] || read_ok_s);
            urgent_s[i] = elig_s[i] && (age_r[i] == AW'(AGE_MAX));
        end
        any_urgent_s = |urgent_s;
        pool_s       = any_urgent_s ? urgent_s : elig_s;
    end

    // Round-robin search of the pool starting at rr_ptr.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDW'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!win_found_s && pool_s[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // One-hot ready for the winner and one-hot response strobe for the FIFO head.
    always_comb begin
        req_ready_s = '0;
        rsp_valid_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_s[i] = grant_s && (win_id_s == IDW'(i));
            rsp_valid_s[i] = fifo_pop_s && (fifo_head_s == IDW'(i));
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stage_r      <= '0;
            sram_valid_r <= 1'b0;
            sram_id_r    <= '0;
            rr_ptr_r     <= '0;
        end else if (grant_s) begin
            stage_r <= '{write: bus.req_write[win_id_s],
                         slot:  bus.req_slot[win_id_s],
                         shift: bus.req_shift[win_id_s],
                         mask:  bus.req_mask[win_id_s],
                         data:  bus.req_wdata[win_id_s]};
            sram_valid_r <= 1'b1;
            sram_id_r    <= win_id_s;
            rr_ptr_r     <= IDW'(rr_next(int'(win_id_s), NUM_REQ));
        end else if (bus.sram_ready) begin
            sram_valid_r <= 1'b0;
        end
    end

    // Per-requester wait age, saturating; cleared on grant or when the request drops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                age_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] || req_ready_s[i]) begin
                    age_r[i] <= '0;
                end else if (age_r[i] != AW'(AGE_MAX)) begin
                    age_r[i] <= age_r[i] + AW'(1);
                end
            end
        end
    end

    // Outstanding read count and sticky response-underflow flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_cnt_r <= '0;
            err_r     <= 1'b0;
        end else begin
            case ({grant_read_s, fifo_pop_s})
                2'b10:   out_cnt_r <= out_cnt_r + CW'(1);
                2'b01:   out_cnt_r <= out_cnt_r - CW'(1);
                default: out_cnt_r <= out_cnt_r;
            endcase
            if (bus.sram_rsp_valid && fifo_empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

    scpad_rsp_id_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (IDW)
    ) u_rsp_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .push    (grant_read_s),
        .push_id (win_id_s),
        .pop     (fifo_pop_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .head    (fifo_head_s)
    );

    assign bus.req_ready   = req_ready_s;
    assign bus.sram_valid  = sram_valid_r;
    assign bus.sram_write  = stage_r.write;
    assign bus.sram_slot   = stage_r.slot;
    assign bus.sram_shift  = stage_r.shift;
    assign bus.sram_mask   = stage_r.mask;
    assign bus.sram_wdata  = stage_r.data;
    assign bus.sram_id     = sram_id_r;
    assign bus.rsp_valid   = rsp_valid_s;
    assign bus.rsp_data    = bus.sram_rsp_data;
    assign bus.err_rsp_unf = err_r;

endmodule

// File: tb/tb_scpad_frontend_arb.sv
// Bench for scpad_frontend_arb: directed scenarios plus random traffic, all checked
// each cycle against a queue-based transaction-level model of the arbiter.
module tb_scpad_frontend_arb;
    import scpad_frontend_arb_pkg::*;

    localparam int N     = FE_NUM_REQ;
    localparam int DEPTH = 4;
    localparam int AMAX  = 3;
    localparam int DLY   = 2;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    scpad_frontend_arb_if #(.NUM_REQ(N)) bus ();

    scpad_frontend_arb #(
        .NUM_REQ   (N),
        .RSP_DEPTH (DEPTH),
        .AGE_MAX   (AMAX)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: registered stage, rr pointer, ages, outstanding read ids, error flag.
    bit         m_valid;
    scpad_req_t m_stage;
    int         m_id;
    int         m_rr;
    int         m_age [N];
    int         m_q [$];
    bit         m_err;
    int         pend [$];
    int         cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_valid = 1'b0;
        m_stage = '0;
        m_id    = 0;
        m_rr    = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_q.delete();
        m_err = 1'b0;
        pend.delete();
    endtask

    // SRAM model: answer an accepted read DLY cycles after acceptance, with probability pct.
    function automatic bit auto_rsp(input int pct);
        return (pend.size() > 0) && (pend[0] <= cyc) && ($urandom_range(99) < pct);
    endfunction

    // One clock cycle: drive at negedge, check just after, then advance the model.
    task automatic step(input bit rst_n, input logic [N-1:0] v, input logic [N-1:0] w,
                        input bit rdy, input bit rspv);
        bit          free;
        bit          found;
        int          win;
        int          idx;
        logic [N-1:0] elig, urg, pool, exp_ready, exp_rsp;
        scpad_data_t rdata;
        @(negedge CLK);
        nRST = rst_n;
        bus.req_valid = v;
        bus.req_write = w;
        for (int i = 0; i < N; i++) begin
            bus.req_slot[i]  = slot_mask_t'($urandom);
            bus.req_shift[i] = shift_mask_t'($urandom);
            bus.req_mask[i]  = valid_mask_t'($urandom);
            bus.req_wdata[i] = scpad_data_t'($urandom);
        end
        rdata = scpad_data_t'($urandom);
        bus.sram_ready     = rdy;
        bus.sram_rsp_valid = rspv;
        bus.sram_rsp_data  = rdata;
        #1;
        if (!rst_n) m_reset();

        free = rst_n && (!m_valid || rdy);
        for (int i = 0; i < N; i++) begin
            elig[i] = v[i] && (w[i] || (m_q.size() < DEPTH));
            urg[i]  = elig[i] && (m_age[i] == AMAX);
        end
        pool  = (urg != '0) ? urg : elig;
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!found && pool[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        exp_ready = '0;
        if (free && found) exp_ready[win] = 1'b1;
        exp_rsp = '0;
        if (rspv && (m_q.size() > 0)) exp_rsp[m_q[0]] = 1'b1;

        check_eq("req_ready",  64'(bus.req_ready),   64'(exp_ready));
        check_eq("rsp_valid",  64'(bus.rsp_valid),   64'(exp_rsp));
        check_eq("rsp_data",   64'(bus.rsp_data),    64'(rdata));
        check_eq("sram_valid", 64'(bus.sram_valid),  64'(m_valid));
        check_eq("sram_id",    64'(bus.sram_id),     64'(m_id));
        check_eq("sram_write", 64'(bus.sram_write),  64'(m_stage.write));
        check_eq("sram_slot",  64'(bus.sram_slot),   64'(m_stage.slot));
        check_eq("sram_shift", 64'(bus.sram_shift),  64'(m_stage.shift));
        check_eq("sram_mask",  64'(bus.sram_mask),   64'(m_stage.mask));
        check_eq("sram_wdata", 64'(bus.sram_wdata),  64'(m_stage.data));
        check_eq("err_unf",    64'(bus.err_rsp_unf), 64'(m_err));

        if (rst_n) begin
            if (m_valid && rdy && !m_stage.write) pend.push_back(cyc + DLY);
            if (rspv) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
                if (pend.size() > 0) void'(pend.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (!v[i] || exp_ready[i]) m_age[i] = 0;
                else if (m_age[i] < AMAX) m_age[i] = m_age[i] + 1;
            end
            if (free && found) begin
                m_stage = '{write: w[win], slot: bus.req_slot[win], shift: bus.req_shift[win],
                            mask: bus.req_mask[win], data: bus.req_wdata[win]};
                m_valid = 1'b1;
                m_id    = win;
                m_rr    = (win + 1) % N;
                if (!w[win]) m_q.push_back(win);
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
        cyc++;
    endtask

    int seq [$];
    int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        nRST = 1'b0;
        bus.req_valid = '0; bus.req_write = '0;
        bus.req_slot = '0; bus.req_shift = '0; bus.req_mask = '0; bus.req_wdata = '0;
        bus.sram_ready = 1'b0; bus.sram_rsp_valid = 1'b0; bus.sram_rsp_data = '0;
        m_reset();

        // Reset with everyone requesting, then first grant goes to requester 0.
        repeat (3) step(1'b0, 3'b111, 3'b000, 1'b1, 1'b0);
        check_eq("rst_ready_low", 64'(bus.req_ready), 64'(0));
        step(1'b1, 3'b111, 3'b000, 1'b1, 1'b0);
        check_eq("first_grant_req0", 64'(bus.req_ready), 64'(3'b001));

        // Round-robin fairness with continuous reads and 2-cycle responses.
        repeat (2) step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
        seq.delete();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 3'b111, 3'b000, 1'b1, auto_rsp(100));
            if (bus.sram_valid) seq.push_back(int'(bus.sram_id));
        end
        check_eq("rr_seq_len_ok", 64'(seq.size() >= 6), 64'(1));
        for (int i = 0; i < 6 && i < seq.size(); i++) check_eq("rr_seq", 64'(seq[i]), 64'(exp_seq[i]));

        // Backpressure: stage held for 5 cycles, then resumes.
        repeat (5) begin
            step(1'b1, 3'b111, 3'b000, 1'b0, auto_rsp(100));
            check_eq("bp_ready_low", 64'(bus.req_ready), 64'(0));
        end
        repeat (4) step(1'b1, 3'b111, 3'b000, 1'b1, auto_rsp(100));

        // Credit limit: four reads outstanding block a read but not a write.
        repeat (2) step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
        repeat (4) step(1'b1, 3'b001, 3'b000, 1'b1, 1'b0);
        step(1'b1, 3'b110, 3'b100, 1'b1, 1'b0);
        check_eq("credit_write_only", 64'(bus.req_ready), 64'(3'b100));
        step(1'b1, 3'b010, 3'b000, 1'b1, 1'b1);
        check_eq("credit_read_held", 64'(bus.req_ready), 64'(0));
        check_eq("credit_rsp_req0", 64'(bus.rsp_valid), 64'(3'b001));
        step(1'b1, 3'b010, 3'b000, 1'b1, 1'b0);
        check_eq("credit_read_freed", 64'(bus.req_ready), 64'(3'b010));

        // Aging: requester 2 waits through a blocked stage and wins when it frees.
        repeat (2) step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
        repeat (4) step(1'b1, 3'b011, 3'b111, 1'b1, 1'b0);
        repeat (3) step(1'b1, 3'b111, 3'b111, 1'b0, 1'b0);
        step(1'b1, 3'b111, 3'b111, 1'b1, 1'b0);
        check_eq("aging_req2_wins", 64'(bus.req_ready), 64'(3'b100));

        // Random traffic with occasional reset.
        repeat (2) step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(399) != 0), N'($urandom), N'($urandom),
                 ($urandom_range(3) != 0), auto_rsp(70));
        end

        // Underflow: response with nothing outstanding sets a sticky error.
        repeat (2) step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b1, 1'b1);
        check_eq("unf_no_rsp", 64'(bus.rsp_valid), 64'(0));
        repeat (3) begin
            step(1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
            check_eq("unf_sticky", 64'(bus.err_rsp_unf), 64'(1));
        end
        step(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
        check_eq("unf_cleared", 64'(bus.err_rsp_unf), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
